// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stage indices address the enable and clear vectors.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    localparam int REG_W_DEF = 5;
    localparam int ZERO_REG  = 0;

    localparam int EN_PC    = 0;
    localparam int EN_IFID  = 1;
    localparam int EN_IDEX  = 2;
    localparam int EN_EXMEM = 3;
    localparam int EN_MEMWB = 4;
    localparam int N_EN     = 5;

    localparam int CLR_IFID  = 0;
    localparam int CLR_IDEX  = 1;
    localparam int CLR_EXMEM = 2;
    localparam int N_CLR     = 3;

    // Front end frozen, only the stages behind EX keep moving.
    function automatic logic [N_EN-1:0] md_en_vec();
        logic [N_EN-1:0] v;
        v = '0;
        v[EN_EXMEM] = 1'b1;
        v[EN_MEMWB] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and register enable/clear outputs of the sequencer.
// PIPE_HAZARD_CTRL_PERF_EN adds the stall/flush counters.
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) ();

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             branch_taken;
    logic             md_start;

    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic clr_ifid;
    logic clr_idex;
    logic clr_exmem;
    logic md_busy;
    logic md_done;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt,
        output idex_memread, idex_rt,
        output branch_taken, md_start,
        input  en_pc, en_ifid, en_idex,
        input  en_exmem, en_memwb,
        input  clr_ifid, clr_idex, clr_exmem,
        input  md_busy, md_done
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        input  stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt,
        input  idex_memread, idex_rt,
        input  branch_taken, md_start,
        output en_pc, en_ifid, en_idex,
        output en_exmem, en_memwb,
        output clr_ifid, clr_idex, clr_exmem,
        output md_busy, md_done
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_countdown.sv
// Loadable down-counter that flags the last cycle of a multi-cycle op.
// Holds at zero instead of wrapping.
module md_countdown #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken-branch and mult/div occupancy.
// PIPE_HAZARD_CTRL_PERF_EN enables the stall and flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int REG_W  = REG_W_DEF
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int CW = $clog2(MD_LAT) + 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT - 1);
    localparam logic [REG_W-1:0] R0 = REG_W'(ZERO_REG);

    state_t state;
    state_t state_nxt;

    logic             armed_q;
    logic             stall_q;
    logic [N_EN-1:0]  en;
    logic [N_CLR-1:0] clr;
    logic             md_go;
    logic             md_last;
    logic             md_busy_c;
    logic             md_done_c;
    logic             load_use;
    logic             stall;

    // A stall in the previous cycle already produced this load's bubble.
    assign load_use = hz.idex_memread
                   && hz.idex_rt != R0
                   && (hz.idex_rt == hz.id_rs
                       || (hz.id_uses_rt
                           && hz.idex_rt == hz.id_rt))
                   && !stall_q;

    always_comb begin
        state_nxt = state;
        en        = '1;
        clr       = '0;
        md_go     = 1'b0;
        md_busy_c = 1'b0;
        md_done_c = 1'b0;
        stall     = 1'b0;
        unique case (state)
            INIT: begin
                en        = '0;
                clr       = '1;
                state_nxt = RUN;
            end
            RUN: begin
                if (hz.md_start && armed_q) begin
                    md_go          = 1'b1;
                    md_busy_c      = 1'b1;
                    en             = md_en_vec();
                    clr[CLR_EXMEM] = 1'b1;
                    state_nxt      = MD_BUSY;
                end else if (load_use) begin
                    stall         = 1'b1;
                    en[EN_PC]     = 1'b0;
                    en[EN_IFID]   = 1'b0;
                    clr[CLR_IDEX] = 1'b1;
                end else if (hz.branch_taken) begin
                    clr[CLR_IFID] = 1'b1;
                end
            end
            MD_BUSY: begin
                md_busy_c      = 1'b1;
                en             = md_en_vec();
                clr[CLR_EXMEM] = !md_last;
                md_done_c      = md_last;
                if (md_last) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT;
            armed_q <= 1'b1;
            stall_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            stall_q <= stall;
            // Re-arm only after md_start drops in RUN.
            if (state == RUN) begin
                if (md_go) begin
                    armed_q <= 1'b0;
                end else if (!hz.md_start) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    md_countdown #(
        .W (CW)
    ) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (md_go),
        .dec      (state == MD_BUSY),
        .load_val (LOAD_VAL),
        .last     (md_last)
    );

    assign hz.en_pc     = en[EN_PC];
    assign hz.en_ifid   = en[EN_IFID];
    assign hz.en_idex   = en[EN_IDEX];
    assign hz.en_exmem  = en[EN_EXMEM];
    assign hz.en_memwb  = en[EN_MEMWB];
    assign hz.clr_ifid  = clr[CLR_IFID];
    assign hz.clr_idex  = clr[CLR_IDEX];
    assign hz.clr_exmem = clr[CLR_EXMEM];
    assign hz.md_busy   = md_busy_c;
    assign hz.md_done   = md_done_c;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        stall_inc;
    logic        flush_inc;

    assign stall_inc = state != INIT && !en[EN_PC];
    assign flush_inc = state == RUN && clr[CLR_IFID];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_inc && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MD_LAT=4.
// Honours PIPE_HAZARD_CTRL_PERF_EN for the counter outputs.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    typedef struct packed {
        logic [4:0] en;
        logic [2:0] clr;
        logic       busy;
        logic       done;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        logic [31:0] sc;
        logic [31:0] fc;
`endif
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_hazard_ctrl_if #(.REG_W(5)) hz ();

    pipe_hazard_ctrl #(
        .MD_LAT (LAT),
        .REG_W  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    bit          m_init  = 1'b1;
    int          m_left  = 0;
    bit          m_armed = 1'b1;
    bit          m_prev  = 1'b0;
    logic [31:0] m_sc    = '0;
    logic [31:0] m_fc    = '0;

    function automatic exp_t sample();
        exp_t a;
        a = '0;
        a.en = {hz.en_memwb, hz.en_exmem, hz.en_idex,
                hz.en_ifid, hz.en_pc};
        a.clr = {hz.clr_exmem, hz.clr_idex, hz.clr_ifid};
        a.busy = hz.md_busy;
        a.done = hz.md_done;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        a.sc = hz.stall_cnt;
        a.fc = hz.flush_cnt;
`endif
        return a;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = sample();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got=%h want=%h",
                         cyc, a, e);
            end
        end
    end

    // Expected outputs come from the rules: reset/first cycle is INIT,
    // a mult/div occupies EX for LAT cycles, one bubble per load.
    task automatic step(input bit r, input bit mr,
                        input int irt, input int rs,
                        input int rt, input bit ut,
                        input bit br, input bit ms);
        exp_t e;
        bit   haz;
        bit   start;
        bit   flush;
        rst             = r;
        hz.idex_memread = mr;
        hz.idex_rt      = 5'(irt);
        hz.id_rs        = 5'(rs);
        hz.id_rt        = 5'(rt);
        hz.id_uses_rt   = ut;
        hz.branch_taken = br;
        hz.md_start     = ms;
        haz   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        e = '0;
        e.en = '1;
        if (!r || m_init) begin
            e.en  = '0;
            e.clr = '1;
        end else if (m_left > 0) begin
            e.en   = 5'b11000;
            e.busy = 1'b1;
            e.done = (m_left == 1);
            e.clr  = {!e.done, 2'b00};
        end else if (ms && m_armed) begin
            start  = 1'b1;
            e.en   = 5'b11000;
            e.busy = 1'b1;
            e.clr  = 3'b100;
        end else begin
            haz = mr && irt != 0 && !m_prev
               && (irt == rs || (ut && irt == rt));
            if (haz) begin
                e.en  = 5'b11100;
                e.clr = 3'b010;
            end else if (br) begin
                flush = 1'b1;
                e.clr = 3'b001;
            end
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        e.sc = r ? m_sc : 32'd0;
        e.fc = r ? m_fc : 32'd0;
`endif
        sb.push_back(e);
        @(posedge clk);
        cyc++;
        if (!r) begin
            m_init  = 1'b1;
            m_left  = 0;
            m_armed = 1'b1;
            m_prev  = 1'b0;
            m_sc    = '0;
            m_fc    = '0;
        end else begin
            if (!m_init && !e.en[0] && m_sc != '1) m_sc++;
            if (flush && m_fc != '1) m_fc++;
            if (m_init) begin
                m_init = 1'b0;
                m_prev = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                m_prev = 1'b0;
            end else if (start) begin
                m_left  = LAT - 1;
                m_armed = 1'b0;
                m_prev  = 1'b0;
            end else begin
                if (!ms) m_armed = 1'b1;
                m_prev = haz;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        hz.idex_memread = 1'b0;
        hz.idex_rt      = '0;
        hz.id_rs        = '0;
        hz.id_rt        = '0;
        hz.id_uses_rt   = 1'b0;
        hz.branch_taken = 1'b0;
        hz.md_start     = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 1, 8, 8, 0, 0, 0, 0);
        step(1, 1, 8, 8, 0, 0, 0, 0);
        idle(1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 3, 8, 0, 0, 0);
        step(1, 1, 8, 3, 8, 1, 0, 0);
        idle(1);
        step(1, 1, 8, 8, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(5);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 1, 5, 5, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(5);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
